// File: rtl/sync_fifo_pkg.sv
// Shared mode constants, status bundle and pointer helper for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    // One extra wrap bit keeps the full and empty states distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer bundle of the FIFO; the bench drives the master side, the FIFO is the slave.
interface sync_fifo_fwft_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16
);

    localparam int PTR_WIDTH = ptr_width(DATA_DEPTH);

    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [PTR_WIDTH-1:0]  data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, wr_en, rd_en,
        input  data_out, empty, full, almost_empty, almost_full,
        input  data_count, overflow, underflow
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en,
        output data_out, empty, full, almost_empty, almost_full,
        output data_count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: register array with one synchronous write port and one asynchronous read port.
module sync_fifo_ram #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DATA_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, level flags, flush and error pulses.
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DATA_DEPTH = 16,
    parameter int  FWFT       = FIFO_MODE_STD,
    parameter int  AF_THRESH  = DATA_DEPTH - 2,
    parameter int  AE_THRESH  = 2,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_fwft_if.slave bus
);

    localparam int PTR_WIDTH = ptr_width(DATA_DEPTH);
    localparam logic [PTR_WIDTH-1:0] DEPTH_CNT = PTR_WIDTH'(DATA_DEPTH);
    localparam logic [PTR_WIDTH-1:0] AF_CNT    = PTR_WIDTH'(AF_THRESH);
    localparam logic [PTR_WIDTH-1:0] AE_CNT    = PTR_WIDTH'(AE_THRESH);

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]  count;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    fifo_status_t          status;

    // Pointer difference wraps modulo 2*DATA_DEPTH, so it is the fill level directly.
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        status.empty        = (count == '0);
        status.full         = (count == DEPTH_CNT);
        status.almost_empty = (count <= AE_CNT);
        status.almost_full  = (count >= AF_CNT);
    end

    // A full FIFO still takes a write when the head word leaves in the same cycle.
    assign rd_acc = bus.rd_en & ~status.empty;
    assign wr_acc = bus.wr_en & (~status.full | rd_acc);
    assign ram_we = wr_acc & ~bus.flush;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            overflow_d  = bus.wr_en & ~wr_acc;
            underflow_d = bus.rd_en & ~rd_acc;
        end
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word shown straight from storage; masked while empty so reset and flush read zero.
            assign bus.data_out = status.empty ? '0 : ram_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

            always_comb begin
                data_out_d = data_out_q;
                if (bus.flush) begin
                    data_out_d = '0;
                end else if (rd_acc) begin
                    data_out_d = ram_rdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                end else begin
                    data_out_q <= data_out_d;
                end
            end

            assign bus.data_out = data_out_q;
        end
    endgenerate

    assign bus.empty        = status.empty;
    assign bus.full         = status.full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.data_count   = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-read and an FWFT instance with identical stimulus and compares both against a queue model.
module tb_sync_fifo_fwft;

    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int AF_THRESH = DEPTH - 2;
    localparam int AE_THRESH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_dout_std = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
    logic          exp_fwft_zero = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_fwft_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) if_std ();
    sync_fifo_fwft_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) if_fw ();

    assign if_std.flush   = flush;
    assign if_std.wr_en   = wr_en;
    assign if_std.rd_en   = rd_en;
    assign if_std.data_in = data_in;
    assign if_fw.flush    = flush;
    assign if_fw.wr_en    = wr_en;
    assign if_fw.rd_en    = rd_en;
    assign if_fw.data_in  = data_in;

    sync_fifo_fwft #(
        .DATA_WIDTH (DW), .DATA_DEPTH (DEPTH), .FWFT (0),
        .AF_THRESH (AF_THRESH), .AE_THRESH (AE_THRESH)
    ) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_std)
    );

    sync_fifo_fwft #(
        .DATA_WIDTH (DW), .DATA_DEPTH (DEPTH), .FWFT (1),
        .AF_THRESH (AF_THRESH), .AE_THRESH (AE_THRESH)
    ) u_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, " std.count"}, 32'(if_std.data_count), 32'(n));
        check({tag, " std.empty"}, 32'(if_std.empty), 32'(n == 0));
        check({tag, " std.full"}, 32'(if_std.full), 32'(n == DEPTH));
        check({tag, " std.aempty"}, 32'(if_std.almost_empty), 32'(n <= AE_THRESH));
        check({tag, " std.afull"}, 32'(if_std.almost_full), 32'(n >= AF_THRESH));
        check({tag, " std.ovf"}, 32'(if_std.overflow), 32'(exp_ovf));
        check({tag, " std.unf"}, 32'(if_std.underflow), 32'(exp_unf));
        check({tag, " std.dout"}, 32'(if_std.data_out), 32'(exp_dout_std));
        check({tag, " fw.count"}, 32'(if_fw.data_count), 32'(n));
        check({tag, " fw.empty"}, 32'(if_fw.empty), 32'(n == 0));
        check({tag, " fw.full"}, 32'(if_fw.full), 32'(n == DEPTH));
        check({tag, " fw.ovf"}, 32'(if_fw.overflow), 32'(exp_ovf));
        check({tag, " fw.unf"}, 32'(if_fw.underflow), 32'(exp_unf));
        if (n > 0) begin
            check({tag, " fw.dout"}, 32'(if_fw.data_out), 32'(q[0]));
        end else if (exp_fwft_zero) begin
            check({tag, " fw.dout"}, 32'(if_fw.data_out), 32'd0);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout_std  = '0;
        exp_ovf       = 1'b0;
        exp_unf       = 1'b0;
        exp_fwft_zero = 1'b1;
    endtask

    // Behavioural rules: a read needs a stored word; a write needs room or a same-cycle read.
    task automatic model_apply(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        if (f) begin
            model_reset();
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) exp_dout_std = q.pop_front();
            if (wr_ok) q.push_back(d);
            exp_ovf = w && !wr_ok;
            exp_unf = r && !rd_ok;
        end
    endtask

    task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d,
                        input string tag);
        wr_en   = w;
        rd_en   = r;
        flush   = f;
        data_in = d;
        model_apply(w, r, f, d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(i), "fill");
        end
        step(1'b1, 1'b0, 1'b0, 8'hEE, "overflow");
        step(1'b0, 1'b0, 1'b0, 8'h00, "ovf_clear");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, "drain");
        end
        step(1'b0, 1'b1, 1'b0, 8'h00, "underflow");
        step(1'b0, 1'b1, 1'b0, 8'h00, "underflow2");
        step(1'b0, 1'b0, 1'b0, 8'h00, "unf_clear");

        step(1'b1, 1'b0, 1'b0, 8'hA5, "fwft_write");
        step(1'b0, 1'b0, 1'b0, 8'h00, "fwft_hold");
        step(1'b0, 1'b1, 1'b0, 8'h00, "fwft_pop");

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'($urandom), "refill");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, DW'($urandom), "full_rw");
        end

        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, "to_nine");
        end
        step(1'b1, 1'b1, 1'b1, 8'h3C, "flush");
        step(1'b1, 1'b1, 1'b0, 8'h5A, "wr_empty_rd");
        step(1'b0, 1'b1, 1'b0, 8'h00, "read_back");

        for (int i = 0; i < 600; i++) begin
            bit w, r, f;
            int wbias;
            wbias = (i < 300) ? 65 : 40;
            w = ($urandom_range(0, 99) < wbias);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 199) == 0);
            step(w, r, f, DW'($urandom), "random");
        end

        step(1'b0, 1'b0, 1'b1, 8'h00, "pre_rst_flush");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i), "burst");
        end
        wr_en   = 1'b1;
        data_in = 8'h99;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h77, "post_rst_wr");
        step(1'b0, 1'b1, 1'b0, 8'h00, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO, successor to the basic pointer-based sync FIFO. Adds selectable read mode (standard registered read or first-word-fall-through), fill-level count, programmable almost-full/almost-empty flags, same-cycle read/write when full, synchronous flush and overflow/underflow error pulses. Sits between producer and consumer blocks in one clock domain wherever the plain FIFO lacks flow-control headroom.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DATA_DEPTH, 16, entries; power of two, ≥4
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AF_THRESH, DATA_DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DATA_DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DATA_DEPTH-1)
- ADDR_WIDTH, $clog2(DATA_DEPTH), derived; not overridden
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous discard of all contents
- data_in  input  DATA_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request (standard) / pop of head word (FWFT)
- data_out  output  DATA_WIDTH  read data
- empty  output  1  no stored words
- full  output  1  DATA_DEPTH words stored
- almost_empty  output  1  count ≤ AE_THRESH
- almost_full  output  1  count ≥ AF_THRESH
- data_count  output  ADDR_WIDTH+1  stored words, 0..DATA_DEPTH
- overflow  output  1  one-cycle pulse: write request rejected
- underflow  output  1  one-cycle pulse: read request rejected

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; low bits address storage, MSB is wrap bit; increment wraps naturally modulo 2·DATA_DEPTH.
- data_count = wr_ptr − rd_ptr (modulo ADDR_WIDTH+1 bits). empty = (count==0); full = (count==DATA_DEPTH); almost flags compare count. All combinational from registered pointers.
- rd_acc = rd_en & ~empty. wr_acc = wr_en & (~full | rd_acc): write into full FIFO accepted when a read is accepted same cycle; count unchanged.
- Write into empty FIFO with simultaneous rd_en: read rejected (underflow pulse), write accepted.
- overflow <= wr_en & ~wr_acc; underflow <= rd_en & ~rd_acc; registered, asserted the cycle after the rejected request.
- flush: highest priority; pointers to 0, same-cycle wr/rd ignored, no error pulses, data_out to 0. Storage contents not cleared.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr]; otherwise data_out holds.
- FWFT=1: data_out = mem[rd_ptr] continuously; valid only while ~empty; rd_acc advances to next word.

## Timing
- Reset (rst_n low, immediate): pointers 0, data_out 0, empty 1, almost_empty 1, full 0, almost_full 0 (unless AF_THRESH==0, disallowed), data_count 0, overflow/underflow 0.
- Write-to-flags: write accepted at edge N → count/empty/full update after edge N.
- Standard read latency: rd_acc at edge N → data_out valid after edge N.
- FWFT write-to-data: write into empty FIFO at edge N → data_out shows word and empty=0 after edge N.
- Error pulses: exactly one cycle per rejected request, consecutive rejects give consecutive pulses.
- rst_n deasserted mid-burst: FIFO restarts empty; no partial state retained.

## Structure
- Package sync_fifo_pkg: mode constants FIFO_MODE_STD=0, FIFO_MODE_FWFT=1; function for pointer width.
- Sub-module sync_fifo_ram: DATA_DEPTH×DATA_WIDTH register array, one synchronous write port, one asynchronous read port; top holds pointers, flags, output register.

## Test plan
- Reset, write 0x01..0x10 (DEPTH 16) → full=1 after 16th edge, almost_full from count 14, 17th write → overflow pulse, count stays 16.
- Read all 16, FWFT=0 → data_out 0x01..0x10 each one cycle after rd_en; 17th rd_en → underflow pulse, empty=1.
- FWFT=1: single write 0xA5 → data_out=0xA5, empty=0 next cycle without rd_en; rd_en → empty=1.
- Full FIFO, wr_en&rd_en together for 20 cycles → no overflow, count stays 16, order preserved across pointer wrap.
- Count 9, flush with wr_en&rd_en high → count 0, empty=1, no error pulses, data_out 0.
- Assert rst_n low mid-write burst at count 5 → all outputs to reset values immediately; next write lands at address 0.
